up_master_bridge: RTL and testbench



---
 rtl/up_master_bridge_pkg.sv | 12 +
 rtl/up_tout_cnt.sv | 35 +++
 rtl/up_master_bridge.sv | 177 +++++++++++++++++
 tb/tb_up_master_bridge.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/up_master_bridge_pkg.sv
// Shared encodings for the up master bridge: FSM state values and command type.
package up_master_bridge_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    STRB = 2'd1,
    WAIT = 2'd2,
    GAP  = 2'd3
  } state_t;

  localparam logic CMD_RD = 1'b0;
  localparam logic CMD_WR = 1'b1;
endpackage

// File: rtl/up_tout_cnt.sv
// Timeout counter for the up bridge: cleared by clr_i, counts while en_i is high.
// expire_o marks the last allowed wait cycle (count == G_TOUT-1 while enabled); combinational.
module up_tout_cnt #(
  parameter int G_TWIDTH = 8,
  parameter int G_TOUT   = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);
  localparam logic [G_TWIDTH-1:0] C_LAST = G_TWIDTH'(G_TOUT - 1);

  logic [G_TWIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire_o = en_i && (cnt_q == C_LAST);
endmodule

// File: rtl/up_master_bridge.sv
// up protocol initiator: one register access per accepted command, response strobe after uprdy/timeout (accept->rsp = 2 + wait cycles).
// No response backpressure; requests ignored while busy. UP_MASTER_BRIDGE_RETRY_EN re-strobes once after a first timeout.
module up_master_bridge #(
  parameter int G_ADDR   = 10,
  parameter int G_WIDTH  = 32,
  parameter int G_TOUT   = 255,
  parameter int G_TWIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_vld,
  output logic               req_rdy,
  input  logic               req_wr,
  input  logic [G_ADDR-1:0]  req_addr,
  input  logic [G_WIDTH-1:0] req_wdata,
  output logic               rsp_vld,
  output logic               rsp_err,
  output logic [G_WIDTH-1:0] rsp_rdata,
  output logic               upen,
  output logic [G_ADDR-1:0]  upa,
  output logic               upws,
  output logic               uprs,
  output logic [G_WIDTH-1:0] updi,
  input  logic [G_WIDTH-1:0] updo,
  input  logic               uprdy
);
  import up_master_bridge_pkg::*;

  state_t               state_q, state_d;
  logic                 cmd_wr_q, cmd_wr_d;
  logic [G_ADDR-1:0]    upa_q, upa_d;
  logic [G_WIDTH-1:0]   updi_q, updi_d;
  logic [G_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                 req_rdy_q, req_rdy_d;
  logic                 rsp_vld_q, rsp_vld_d;
  logic                 rsp_err_q, rsp_err_d;
  logic                 upen_q, upen_d;
  logic                 upws_q, upws_d;
  logic                 uprs_q, uprs_d;
  logic                 expire;
`ifdef UP_MASTER_BRIDGE_RETRY_EN
  logic                 retry_q, retry_d;
`endif

  up_tout_cnt #(
    .G_TWIDTH (G_TWIDTH),
    .G_TOUT   (G_TOUT)
  ) u_tout (
    .clk      (clk),
    .rst      (rst),
    .clr_i    (state_q == STRB),
    .en_i     (state_q == WAIT),
    .expire_o (expire)
  );

  always_comb begin
    state_d     = state_q;
    cmd_wr_d    = cmd_wr_q;
    upa_d       = upa_q;
    updi_d      = updi_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    req_rdy_d   = 1'b0;
    rsp_vld_d   = 1'b0;
    upen_d      = upen_q;
    upws_d      = 1'b0;
    uprs_d      = 1'b0;
`ifdef UP_MASTER_BRIDGE_RETRY_EN
    retry_d     = retry_q;
`endif
    case (state_q)
      IDLE: begin
        req_rdy_d = 1'b1;
`ifdef UP_MASTER_BRIDGE_RETRY_EN
        retry_d   = 1'b0;
`endif
        if (req_vld) begin
          state_d   = STRB;
          req_rdy_d = 1'b0;
          cmd_wr_d  = req_wr;
          upa_d     = req_addr;
          updi_d    = req_wdata;
          upen_d    = 1'b1;
          upws_d    = (req_wr == CMD_WR);
          uprs_d    = (req_wr == CMD_RD);
        end
      end
      STRB, WAIT: begin
        if (state_q == STRB) begin
          state_d = WAIT;
        end
        // uprdy takes priority over an expiring counter in the same cycle
        if (uprdy) begin
          state_d     = GAP;
          upen_d      = 1'b0;
          rsp_vld_d   = 1'b1;
          rsp_err_d   = 1'b0;
          rsp_rdata_d = (cmd_wr_q == CMD_WR) ? '0 : updo;
        end else if (expire) begin
          state_d = GAP;
          upen_d  = 1'b0;
`ifdef UP_MASTER_BRIDGE_RETRY_EN
          retry_d = 1'b1;
          if (retry_q) begin
            rsp_vld_d   = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_rdata_d = '0;
          end
`else
          rsp_vld_d   = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_rdata_d = '0;
`endif
        end
      end
      GAP: begin
        state_d   = IDLE;
        req_rdy_d = 1'b1;
`ifdef UP_MASTER_BRIDGE_RETRY_EN
        // a silent GAP means the first attempt timed out: strobe the same command again
        if (!rsp_vld_q) begin
          state_d   = STRB;
          req_rdy_d = 1'b0;
          upen_d    = 1'b1;
          upws_d    = (cmd_wr_q == CMD_WR);
          uprs_d    = (cmd_wr_q == CMD_RD);
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cmd_wr_q    <= CMD_RD;
      upa_q       <= '0;
      updi_q      <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      req_rdy_q   <= 1'b1;
      rsp_vld_q   <= 1'b0;
      upen_q      <= 1'b0;
      upws_q      <= 1'b0;
      uprs_q      <= 1'b0;
`ifdef UP_MASTER_BRIDGE_RETRY_EN
      retry_q     <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cmd_wr_q    <= cmd_wr_d;
      upa_q       <= upa_d;
      updi_q      <= updi_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      req_rdy_q   <= req_rdy_d;
      rsp_vld_q   <= rsp_vld_d;
      upen_q      <= upen_d;
      upws_q      <= upws_d;
      uprs_q      <= uprs_d;
`ifdef UP_MASTER_BRIDGE_RETRY_EN
      retry_q     <= retry_d;
`endif
    end
  end

  assign req_rdy   = req_rdy_q;
  assign rsp_vld   = rsp_vld_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;
  assign upen      = upen_q;
  assign upa       = upa_q;
  assign upws      = upws_q;
  assign uprs      = uprs_q;
  assign updi      = updi_q;
endmodule

// File: tb/tb_up_master_bridge.sv
// Bench for up_master_bridge: reactive up slave with per-attempt delay, transaction-level expectations.
module tb_up_master_bridge;
  localparam int TOUT  = 8;
  localparam int NEVER = 1000;

  logic        clk;
  logic        rst;
  logic        req_vld;
  logic        req_rdy;
  logic        req_wr;
  logic [9:0]  req_addr;
  logic [31:0] req_wdata;
  logic        rsp_vld;
  logic        rsp_err;
  logic [31:0] rsp_rdata;
  logic        upen;
  logic [9:0]  upa;
  logic        upws;
  logic        uprs;
  logic [31:0] updi;
  logic [31:0] updo;
  logic        uprdy;

  int n_chk;
  int n_err;

  up_master_bridge #(
    .G_ADDR   (10),
    .G_WIDTH  (32),
    .G_TOUT   (TOUT),
    .G_TWIDTH (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_vld   (req_vld),
    .req_rdy   (req_rdy),
    .req_wr    (req_wr),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_vld   (rsp_vld),
    .rsp_err   (rsp_err),
    .rsp_rdata (rsp_rdata),
    .upen      (upen),
    .upa       (upa),
    .upws      (upws),
    .uprs      (uprs),
    .updi      (updi),
    .updo      (updo),
    .uprdy     (uprdy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge of the idle cycle after the response.
  // d1/d2: offset of uprdy from the first/second strobe cycle (0 = during the strobe itself).
  task automatic run_txn(input logic wr, input logic [9:0] a, input logic [31:0] wd,
                         input logic [31:0] rd, input int d1, input int d2);
    int since, strb_n, upen_n, rsp_cyc, att_d, lat, exp_upen, exp_att, l1, l2;
    logic exp_err, got_err, gap_upen;
    logic [31:0] got_rdata, exp_rdata;
    since = -1; strb_n = 0; upen_n = 0; rsp_cyc = -1; att_d = NEVER;
    got_err = 1'b0; got_rdata = '0; gap_upen = 1'b0;

    chk("idle_rdy", 64'(req_rdy), 64'(1));
    req_vld = 1'b1; req_wr = wr; req_addr = a; req_wdata = wd;
    uprdy = 1'($urandom_range(0, 1)); updo = $urandom;
    for (int cyc = 1; cyc <= 100 && rsp_cyc < 0; cyc++) begin
      @(negedge clk);
      req_vld   = 1'($urandom_range(0, 1));
      req_wr    = 1'($urandom_range(0, 1));
      req_addr  = 10'($urandom);
      req_wdata = $urandom;
      if (cyc == 1) chk("busy_rdy", 64'(req_rdy), 64'(0));
      if (upws || uprs) begin
        strb_n++;
        since = 0;
        att_d = (strb_n == 1) ? d1 : d2;
        chk("strb_bus", 64'({upa, updi, upws, uprs}), 64'({a, wd, wr, ~wr}));
      end else if (since >= 0) begin
        since++;
      end
      if (upen) upen_n++;
      if (rsp_vld) begin
        rsp_cyc = cyc; got_err = rsp_err; got_rdata = rsp_rdata; gap_upen = upen;
        uprdy = 1'($urandom_range(0, 1)); updo = $urandom;
      end else begin
        uprdy = (since == att_d);
        updo  = (since == att_d) ? rd : $urandom;
      end
    end

    l1 = (d1 <= TOUT) ? d1 + 1 : TOUT + 1;
    l2 = (d2 <= TOUT) ? d2 + 1 : TOUT + 1;
    exp_att = 1; exp_upen = l1; lat = 1 + l1; exp_err = (d1 > TOUT);
`ifdef UP_MASTER_BRIDGE_RETRY_EN
    if (d1 > TOUT) begin
      exp_att = 2; exp_upen = l1 + l2; lat = 2 + l1 + l2; exp_err = (d2 > TOUT);
    end
`endif
    exp_rdata = (exp_err || wr) ? 32'h0 : rd;

    chk("rsp_cycle", 64'(rsp_cyc), 64'(lat));
    chk("strobes", 64'(strb_n), 64'(exp_att));
    chk("upen_cycles", 64'(upen_n), 64'(exp_upen));
    chk("rsp_err", 64'(got_err), 64'(exp_err));
    chk("rsp_rdata", 64'(got_rdata), 64'(exp_rdata));
    chk("gap_upen", 64'(gap_upen), 64'(0));
    @(negedge clk);
    chk("rsp_one_cycle", 64'(rsp_vld), 64'(0));
    chk("back_rdy", 64'(req_rdy), 64'(1));
    req_vld = 1'b0; uprdy = 1'b0;
  endtask

  // req_vld held high with fresh inputs every cycle against a slave answering one cycle after the strobe.
  task automatic run_stream(input int n);
    logic        s_wr [64];
    logic [9:0]  s_a  [64];
    logic [31:0] s_wd [64];
    logic [31:0] s_do [64];
    logic strb, prev;
    prev = 1'b0;
    for (int c = 0; c < n; c++) begin
      strb = upws | uprs;
      chk("str_rdy", 64'(req_rdy), 64'((c % 4) == 0));
      chk("str_strb", 64'(strb), 64'((c % 4) == 1));
      if ((c % 4) == 1)
        chk("str_bus", 64'({upa, updi, upws, uprs}), 64'({s_a[c-1], s_wd[c-1], s_wr[c-1], ~s_wr[c-1]}));
      chk("str_rsp", 64'(rsp_vld), 64'((c % 4) == 3));
      if ((c % 4) == 3)
        chk("str_rdata", 64'({rsp_err, rsp_rdata}), 64'({1'b0, s_wr[c-3] ? 32'h0 : s_do[c-1]}));
      s_wr[c] = 1'($urandom_range(0, 1));
      s_a[c]  = 10'($urandom);
      s_wd[c] = $urandom;
      s_do[c] = $urandom;
      req_vld = 1'b1; req_wr = s_wr[c]; req_addr = s_a[c]; req_wdata = s_wd[c];
      updo = s_do[c]; uprdy = prev;
      prev = strb;
      @(negedge clk);
    end
    req_vld = 1'b0; uprdy = 1'b0;
  endtask

  initial begin
    int d1, d2, hits;
    n_chk = 0; n_err = 0;
    rst = 1'b1; req_vld = 1'b0; req_wr = 1'b0; req_addr = '0; req_wdata = '0;
    updo = '0; uprdy = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_ctl", 64'({req_rdy, rsp_vld, rsp_err, upen, upws, uprs}), 64'(6'b100000));
    chk("rst_rdata", 64'(rsp_rdata), 64'(0));
    chk("rst_upbus", 64'({upa, updi}), 64'(0));
    rst = 1'b0;
    @(negedge clk);

    run_txn(1'b1, 10'h005, 32'hDEADBEEF, 32'h0, 2, NEVER);
    run_txn(1'b0, 10'h3FF, 32'h0, 32'h12345678, 2, NEVER);
    run_txn(1'b0, 10'h0AA, 32'h0, 32'h11111111, NEVER, NEVER);
    run_txn(1'b0, 10'h155, 32'h0, 32'hCAFEF00D, TOUT, NEVER);
    run_txn(1'b1, 10'h200, 32'h0BADF00D, 32'h0, TOUT + 1, 3);
    run_txn(1'b0, 10'h001, 32'h0, 32'hA5A5A5A5, 0, NEVER);
    run_txn(1'b0, 10'h3C3, 32'h0, 32'h5A5A5A5A, TOUT + 1, TOUT);

    for (int i = 0; i < 30; i++) begin
      d1 = $urandom_range(0, 11);
      d2 = $urandom_range(0, 11);
      if (d1 == 11) d1 = NEVER;
      if (d2 == 11) d2 = NEVER;
      run_txn(1'($urandom_range(0, 1)), 10'($urandom), $urandom, $urandom, d1, d2);
    end

    run_stream(40);

    req_vld = 1'b1; req_wr = 1'b0; req_addr = 10'h123; uprdy = 1'b0;
    @(negedge clk);
    req_vld = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_mid_upen", 64'(upen), 64'(0));
    chk("rst_mid_rsp", 64'(rsp_vld), 64'(0));
    chk("rst_mid_rdy", 64'(req_rdy), 64'(1));
    @(negedge clk);
    rst = 1'b0;
    hits = 0;
    repeat (2 * TOUT + 4) begin
      @(negedge clk);
      if (rsp_vld || upen) hits++;
    end
    chk("rst_no_rsp", 64'(hits), 64'(0));
    run_txn(1'b0, 10'h2A5, 32'h0, 32'h76543210, 1, NEVER);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
